// File: rtl/crate_merge_pkg.sv
// rtl/crate_merge_pkg.sv - shared frame geometry, header layout and state type for the crate frame merger
package crate_merge_pkg;

  localparam int ROWS    = 38;
  localparam int ROW_W   = 38;
  localparam int FRAME_W = ROWS * ROW_W;
  localparam int IDX_W   = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  localparam logic [15:0] HDR_MAGIC = 16'hAAAA;
  localparam int EVID_LSB     = 16;
  localparam int EVID_W       = 10;
  localparam int MASK_LSB     = 26;
  localparam int MISMATCH_BIT = 35;
  localparam int TIMEOUT_BIT  = 36;
  localparam int VALID_BIT    = 37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SEND_HDR,
    ST_SEND_ROWS
  } merge_state_e;

  // rx_mask is passed zero-extended to 8 bits so bits above NUM_SRC stay clear
  function automatic logic [ROW_W-1:0] make_header(
    input logic [EVID_W-1:0] ev_id,
    input logic [7:0]        rx_mask,
    input logic              mismatch,
    input logic              timeout
  );
    logic [ROW_W-1:0] h;
    h                     = '0;
    h[15:0]               = HDR_MAGIC;
    h[EVID_LSB +: EVID_W] = ev_id;
    h[MASK_LSB +: 8]      = rx_mask;
    h[MISMATCH_BIT]       = mismatch;
    h[TIMEOUT_BIT]        = timeout;
    h[VALID_BIT]          = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/frame_row_accumulator.sv
// rtl/frame_row_accumulator.sv - 38x38 OR-accumulating hit map with clear and indexed row read
module frame_row_accumulator
  import crate_merge_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [NUM_SRC-1:0]         or_en,
  input  logic [NUM_SRC*FRAME_W-1:0] src_rows,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [ROW_W-1:0]           rd_row
);

  logic [ROW_W-1:0] rows_q [ROWS];
  logic [ROW_W-1:0] rows_d [ROWS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      rows_d[r] = rows_q[r];
      for (int s = 0; s < NUM_SRC; s++) begin
        if (or_en[s]) begin
          rows_d[r] = rows_d[r] | src_rows[s*FRAME_W + r*ROW_W +: ROW_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int r = 0; r < ROWS; r++) begin
        rows_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        rows_q[r] <= rows_d[r];
      end
    end
  end

  // Index one past the last row reads as zero; the top prefetches idx+1
  always_comb begin
    rd_row = '0;
    if (rd_idx <= LAST_IDX) begin
      rd_row = rows_q[rd_idx];
    end
  end

endmodule

// File: rtl/crate_frame_merger.sv
// rtl/crate_frame_merger.sv - merges per-crate mapped frames of one event and streams the hit map
module crate_frame_merger
  import crate_merge_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int DROP_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_mask,
  input  logic [NUM_SRC*ROW_W-1:0]   src_header,
  input  logic [NUM_SRC*FRAME_W-1:0] src_rows,
  output logic [ROW_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam int SUM_W = DROP_W + 4;

  merge_state_e       state_q, state_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] rx_q, rx_d;
  logic [EVID_W-1:0]  ev_q, ev_d;
  logic               mism_q, mism_d;
  logic               tmo_flag_q, tmo_flag_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ROW_W-1:0]   data_d;
  logic               valid_d, last_d;
  logic [DROP_W-1:0]  drop_cnt_d;

  logic [NUM_SRC-1:0] eff_mask, arr, accept, drop;
  logic [EVID_W-1:0]  sid [NUM_SRC];
  logic [EVID_W-1:0]  first_id;
  logic               acc_clr;
  logic [IDX_W-1:0]   rd_idx;
  logic [ROW_W-1:0]   rd_row;
  logic [3:0]         drop_n;
  logic [SUM_W-1:0]   drop_sum;

  // The live mask is only honoured while IDLE; an open event keeps the mask it started with
  always_comb begin
    eff_mask = (state_q == ST_IDLE) ? src_mask : mask_q;
    arr      = '0;
    first_id = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      arr[s] = src_header[s*ROW_W + VALID_BIT] & eff_mask[s];
      sid[s] = src_header[s*ROW_W + EVID_LSB +: EVID_W];
    end
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (arr[s]) begin
        first_id = sid[s];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    ev_d       = ev_q;
    mism_d     = mism_q;
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;
    idx_d      = idx_q;
    data_d     = out_data;
    valid_d    = out_valid;
    last_d     = out_last;
    accept     = '0;
    drop       = '0;
    acc_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arr) begin
          ev_d = first_id;
          for (int s = 0; s < NUM_SRC; s++) begin
            if (arr[s]) begin
              if (sid[s] == first_id) accept[s] = 1'b1;
              else                    drop[s]   = 1'b1;
            end
          end
          rx_d      = accept;
          mism_d    = |drop;
          tmo_cnt_d = '0;
          state_d   = (accept == src_mask) ? ST_SEND_HDR : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
          if (arr[s]) begin
            if (!rx_q[s] && (sid[s] == ev_q)) accept[s] = 1'b1;
            else                              drop[s]   = 1'b1;
          end
        end
        rx_d   = rx_q | accept;
        mism_d = mism_q | (|drop);
        if (rx_d == mask_q) begin
          state_d = ST_SEND_HDR;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          state_d    = ST_SEND_HDR;
        end
      end

      ST_SEND_HDR: begin
        drop = arr;
        if (out_ready) begin
          state_d = ST_SEND_ROWS;
          idx_d   = '0;
          data_d  = rd_row;
          last_d  = 1'b0;
        end
      end

      ST_SEND_ROWS: begin
        drop = arr;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            data_d     = '0;
            acc_clr    = 1'b1;
            rx_d       = '0;
            mism_d     = 1'b0;
            tmo_flag_d = 1'b0;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = rd_row;
            last_d = (idx_d == LAST_IDX);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Header is built from this cycle's merged status so it appears one cycle after completion
    if ((state_q == ST_IDLE || state_q == ST_COLLECT) && state_d == ST_SEND_HDR) begin
      valid_d = 1'b1;
      last_d  = 1'b0;
      data_d  = make_header(ev_d, 8'(rx_d), mism_d, tmo_flag_d);
    end
  end

  always_comb begin
    drop_n = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      drop_n = drop_n + 4'(drop[s]);
    end
    drop_sum   = SUM_W'(drop_cnt) + SUM_W'(drop_n);
    drop_cnt_d = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  assign rd_idx = (state_q == ST_SEND_HDR) ? '0 : idx_q + IDX_W'(1);
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      rx_q       <= '0;
      ev_q       <= '0;
      mism_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
      idx_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      if (state_q == ST_IDLE) begin
        mask_q <= src_mask;
      end
      rx_q       <= rx_d;
      ev_q       <= ev_d;
      mism_q     <= mism_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_cnt_q  <= tmo_cnt_d;
      idx_q      <= idx_d;
      out_data   <= data_d;
      out_valid  <= valid_d;
      out_last   <= last_d;
      drop_cnt   <= drop_cnt_d;
    end
  end

  frame_row_accumulator #(
    .NUM_SRC(NUM_SRC)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .or_en   (accept),
    .src_rows(src_rows),
    .rd_idx  (rd_idx),
    .rd_row  (rd_row)
  );

endmodule
